// File: rtl/wr_fram_pkg.sv
// rtl/wr_fram_pkg.sv - shared types and helpers for the frame write pack buffer
// Purpose: burst FSM state encoding, ceil-log2 helper, width-ratio and
//          address-width derivation used by wr_fram_pack_buf and its RAM.
// Ports:   none (package).
package wr_fram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2
   } burst_state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int calc_ratio(input int in_w, input int out_w);
      return out_w / in_w;
   endfunction

   // At least one address bit so a 1-deep buffer still has a legal pointer.
   function automatic int calc_aw(input int depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wr_fram_pack_sdpram.sv
// rtl/wr_fram_pack_sdpram.sv - simple dual-port RAM with registered read port
// Purpose: W x DEPTH storage for committed DDR words. Read is read-before-write:
//          a read and write to the same address in one cycle returns the old word.
// Ports:   clk      - clock
//          wr_en    - write strobe
//          wr_addr  - write address
//          wr_data  - write word
//          rd_addr  - read address, sampled every cycle
//          rd_data  - registered read word
module wr_fram_pack_sdpram
   import wr_fram_pkg::*;
#(
   parameter int W     = 256,
   parameter int DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [calc_aw(DEPTH)-1:0]   wr_addr,
   input  logic [W-1:0]                wr_data,
   input  logic [calc_aw(DEPTH)-1:0]   rd_addr,
   output logic [W-1:0]                rd_data
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rd_data_d;
   logic [W-1:0] rd_data_q;

   always_comb begin
      rd_data_d = mem_q[rd_addr];
   end

   // Storage is deliberately not reset; its contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/wr_fram_pack_buf.sv
// rtl/wr_fram_pack_buf.sv - frame write buffer packing narrow beats into DDR words
// Purpose: packs IN_W beats LSB-first into OUT_W words, queues them in a DEPTH-word
//          RAM and requests a DDR burst once BURST_LEN words are stored.
// Optional feature: define WR_FRAM_PACK_FLUSH_EN to zero-pad and commit the partial
//          word on eof and to allow a short final burst.
// Ports:   clk, rst (async active-high)       sof - synchronous frame clear
//          eof - last beat of frame            in_valid/in_data/in_ready - beat input
//          out_valid/out_data/out_ready - word output
//          burst_req/burst_ack - DDR master handshake
//          level - committed word count        overflow - sticky dropped-beat flag
module wr_fram_pack_buf
   import wr_fram_pkg::*;
#(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 256,
   parameter int DEPTH     = 16,
   parameter int BURST_LEN = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sof,
   input  logic                    eof,
   input  logic                    in_valid,
   input  logic [IN_W-1:0]         in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [OUT_W-1:0]        out_data,
   input  logic                    out_ready,
   output logic                    burst_req,
   input  logic                    burst_ack,
   output logic [clog2(DEPTH):0]   level,
   output logic                    overflow
);

   localparam int RATIO = calc_ratio(IN_W, OUT_W);
   localparam int AW    = calc_aw(DEPTH);
   localparam int LW    = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;

   logic [LW-1:0]    lane_q, lane_d, lane_eff;
   logic [OUT_W-1:0] pack_q, pack_d, word;
   logic [OUT_W-1:0] cword_q, cword_d;
   logic             cpend_q, cpend_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             rd_valid_q, rd_valid_d;
   logic             overflow_q, overflow_d;
   logic             ready_en_q, ready_en_d;
   logic [AW:0]      xfer_cnt_q, xfer_cnt_d, xfer_len_q, xfer_len_d;
   burst_state_e     state_q, state_d;
   logic             pop, accept, last_beat, close, short_ok;
   logic [OUT_W-1:0] rd_data;

`ifdef WR_FRAM_PACK_FLUSH_EN
   logic eof_seen_q, eof_seen_d;

   always_comb begin
      eof_seen_d = eof_seen_q;
      if (sof) begin
         eof_seen_d = accept && eof;
      end else if (accept && eof) begin
         eof_seen_d = 1'b1;
      end
      short_ok = eof_seen_q && (level_q != '0) && (level_q < (AW+1)'(BURST_LEN));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) eof_seen_q <= 1'b0;
      else     eof_seen_q <= eof_seen_d;
   end
`else
   logic unused_eof;
   assign unused_eof = eof;
   assign short_ok   = 1'b0;
`endif

   // Packer, commit stage, pointers and level.
   always_comb begin
      ready_en_d = 1'b1;
      in_ready   = ready_en_q &&
                   (({1'b0, level_q} + (AW+2)'(cpend_q)) < (AW+2)'(DEPTH));
      out_valid  = (level_q != '0) && rd_valid_q;
      pop        = out_valid && out_ready && !sof;
      accept     = in_valid && (in_ready || (sof && ready_en_q));

      // sof restarts the frame, so a same-cycle beat lands in lane 0 of an empty word.
      lane_eff = sof ? '0 : lane_q;
      word     = sof ? '0 : pack_q;
      for (int k = 0; k < RATIO; k++) begin
         if (LW'(k) == lane_eff) word[k*IN_W +: IN_W] = in_data;
      end
      last_beat = (lane_eff == LW'(RATIO-1));
`ifdef WR_FRAM_PACK_FLUSH_EN
      close = last_beat || eof;
`else
      close = last_beat;
`endif

      lane_d     = lane_q;
      pack_d     = pack_q;
      cword_d    = cword_q;
      cpend_d    = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      if (sof) begin
         lane_d     = '0;
         pack_d     = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (cpend_q) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + (AW+1)'(cpend_q) - (AW+1)'(pop);
         if (in_valid && !in_ready) overflow_d = 1'b1;
      end

      // pack_q is cleared on every commit, so unfilled upper lanes of a flushed word are zero.
      if (accept) begin
         if (close) begin
            cword_d = word;
            cpend_d = 1'b1;
            lane_d  = '0;
            pack_d  = '0;
         end else begin
            pack_d = word;
            lane_d = lane_eff + LW'(1);
         end
      end

      // The RAM reads at rd_ptr_d; that word is usable only if it was committed before
      // this edge, since a same-edge write is not visible to the read-before-write port.
      rd_valid_d = !sof && ((level_q - (AW+1)'(pop)) != '0);
   end

   // Burst request FSM.
   always_comb begin
      state_d    = state_q;
      xfer_cnt_d = xfer_cnt_q;
      xfer_len_d = xfer_len_q;
      burst_req  = (state_q == ST_REQ);
      case (state_q)
         ST_IDLE: begin
            if ((level_q >= (AW+1)'(BURST_LEN)) || short_ok) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (burst_ack) begin
               state_d    = ST_XFER;
               xfer_cnt_d = '0;
               xfer_len_d = short_ok ? level_q : (AW+1)'(BURST_LEN);
            end
         end
         ST_XFER: begin
            if (pop) begin
               if ((xfer_cnt_q + (AW+1)'(1)) >= xfer_len_q) state_d = ST_IDLE;
               else                                         xfer_cnt_d = xfer_cnt_q + (AW+1)'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (sof) begin
         state_d    = ST_IDLE;
         xfer_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q     <= '0;
         pack_q     <= '0;
         cword_q    <= '0;
         cpend_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         ready_en_q <= 1'b0;
         xfer_cnt_q <= '0;
         xfer_len_q <= '0;
         state_q    <= ST_IDLE;
      end else begin
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         cword_q    <= cword_d;
         cpend_q    <= cpend_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
         ready_en_q <= ready_en_d;
         xfer_cnt_q <= xfer_cnt_d;
         xfer_len_q <= xfer_len_d;
         state_q    <= state_d;
      end
   end

   wr_fram_pack_sdpram #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (cpend_q && !sof),
      .wr_addr (wr_ptr_q),
      .wr_data (cword_q),
      .rd_addr (rd_ptr_d),
      .rd_data (rd_data)
   );

   assign out_data = out_valid ? rd_data : '0;
   assign level    = level_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_wr_fram_pack_buf.sv
// tb/tb_wr_fram_pack_buf.sv - self-checking bench for wr_fram_pack_buf
module tb_wr_fram_pack_buf;

   localparam int IN_W = 32, OUT_W = 256, DEPTH = 16, BURST_LEN = 8, RATIO = OUT_W / IN_W;

   logic             clk = 1'b0;
   logic             rst, sof, eof, in_valid, out_ready, burst_ack;
   logic [IN_W-1:0]  in_data;
   logic             in_ready, out_valid, burst_req, overflow;
   logic [OUT_W-1:0] out_data;
   logic [4:0]       level;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   wr_fram_pack_buf #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)
   ) dut (
      .clk(clk), .rst(rst), .sof(sof), .eof(eof),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .burst_req(burst_req), .burst_ack(burst_ack),
      .level(level), .overflow(overflow)
   );

   typedef struct {
      int beats;
      int lvl;
      bit rdy;
      bit ov;
      bit br;
      bit ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = IN_W'(base + i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_sof();
      sof = 1'b1;
      tick();
      sof = 1'b0;
   endtask

   task automatic wait_level(input int target, input string name);
      for (int i = 0; i < 40 && level != 5'(target); i++) tick();
      chk(name, level, target);
   endtask

   // Reference word: RATIO consecutive beat values starting at base, lane 0 in the LSBs.
   function automatic logic [OUT_W-1:0] word_of(input int base);
      logic [OUT_W-1:0] w;
      w = '0;
      for (int i = 0; i < RATIO; i++) w[i*IN_W +: IN_W] = IN_W'(base + i);
      return w;
   endfunction

   initial begin
      logic [OUT_W-1:0] exp_q[$];
      logic [OUT_W-1:0] cur;
      logic [OUT_W-1:0] expw;
      int nl, n_pop, max_lvl, bad_rdy;

      rst = 1'b1; sof = 1'b0; eof = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; burst_ack = 1'b0;

      vecs[0] = '{beats: 8,   lvl: 1,  rdy: 1, ov: 1, br: 0, ovf: 0};
      vecs[1] = '{beats: 64,  lvl: 8,  rdy: 1, ov: 1, br: 1, ovf: 0};
      vecs[2] = '{beats: 60,  lvl: 7,  rdy: 1, ov: 1, br: 0, ovf: 0};
      vecs[3] = '{beats: 128, lvl: 16, rdy: 0, ov: 1, br: 1, ovf: 0};
      vecs[4] = '{beats: 129, lvl: 16, rdy: 0, ov: 1, br: 1, ovf: 1};
      vecs[5] = '{beats: 7,   lvl: 0,  rdy: 1, ov: 0, br: 0, ovf: 0};

      // Reset state
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_burst_req", burst_req, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready, 1);

      // Test 1: first-word latency
      push(8, 0);
      chk("lat_n_level", level, 0);
      chk("lat_n_valid", out_valid, 0);
      tick();
      chk("lat_n1_level", level, 1);
      chk("lat_n1_valid", out_valid, 0);
      tick();
      chk("lat_n2_valid", out_valid, 1);
      chk("lat_n2_data", out_data, word_of(0));
      chk("lat_n2_level", level, 1);

      // Test 2: burst handshake
      pulse_sof();
      push(64, 256);
      wait_level(8, "burst_fill");
      tick();
      chk("burst_req_rise", burst_req, 1);
      tick(); tick(); tick();
      chk("burst_req_hold", burst_req, 1);
      burst_ack = 1'b1; tick(); burst_ack = 1'b0;
      chk("burst_req_drop", burst_req, 0);
      for (int k = 0; k < BURST_LEN; k++) begin
         for (int t = 0; t < 10 && !out_valid; t++) tick();
         chk("burst_pop_data", out_data, word_of(256 + k * RATIO));
         out_ready = 1'b1; tick(); out_ready = 1'b0;
      end
      chk("burst_drained_level", level, 0);
      chk("burst_idle_req", burst_req, 0);
      burst_ack = 1'b1; tick(); burst_ack = 1'b0;
      chk("stray_ack_ignored", burst_req, 0);
      push(64, 1024);
      wait_level(8, "burst_refill");
      tick();
      chk("burst_req_again", burst_req, 1);

      // Asynchronous reset in mid-operation
      rst = 1'b1;
      #2;
      chk("async_rst_level", level, 0);
      chk("async_rst_req", burst_req, 0);
      chk("async_rst_valid", out_valid, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("async_rst_ready", in_ready, 1);

      // Table-driven fill patterns, each from a fresh frame
      foreach (vecs[i]) begin
         pulse_sof();
         push(vecs[i].beats, 0);
         tick(); tick(); tick();
         chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
         chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
         chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
         chk($sformatf("vec%0d_burst_req", i), burst_req, vecs[i].br);
         chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
      end
      // Overflow cleared by sof (last full-buffer state came from the 129-beat entry above)
      pulse_sof();
      push(128, 0);
      in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
      chk("ovf_set", overflow, 1);
      pulse_sof();
      chk("ovf_clear_sof", overflow, 0);
      chk("level_clear_sof", level, 0);

      // Test 4: random streaming across several pointer wraps, against a word scoreboard
      pulse_sof();
      out_ready = 1'b1;
      nl = 0; n_pop = 0; max_lvl = 0; bad_rdy = 0; cur = '0;
      for (int cyc = 0; cyc < 720; cyc++) begin
         in_valid = (cyc < 700) && ($urandom_range(0, 3) != 0);
         in_data  = $urandom;
         if (in_valid && in_ready) begin
            cur[nl*IN_W +: IN_W] = in_data;
            nl++;
            if (nl == RATIO) begin
               exp_q.push_back(cur);
               nl = 0;
               cur = '0;
            end
         end
         if (!in_ready) bad_rdy++;
         if (out_valid && out_ready) begin
            chk("stream_pop_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               expw = exp_q.pop_front();
               chk("stream_data", out_data, expw);
               n_pop++;
            end
         end
         if (int'(level) > max_lvl) max_lvl = int'(level);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("stream_all_popped", exp_q.size(), 0);
      chk("stream_wraps", n_pop >= 3 * DEPTH, 1);
      chk("stream_level_max", max_lvl <= 2, 1);
      chk("stream_never_full", bad_rdy, 0);

      // Test 5: sof discards partial word, same-cycle beat becomes lane 0
      pulse_sof();
      push(3, 17);
      sof = 1'b1; in_valid = 1'b1; in_data = 32'hAA;
      tick();
      sof = 1'b0;
      push(7, 32'hB0);
      tick(); tick(); tick();
      chk("sof_partial_level", level, 1);
      chk("sof_lane0", out_data[IN_W-1:0], 32'hAA);
      expw = word_of(32'hAF);
      expw[IN_W-1:0] = 32'hAA;
      chk("sof_word", out_data, expw);

      // Test 6: eof handling
      pulse_sof();
      push(2, 1);
      eof = 1'b1; in_valid = 1'b1; in_data = 32'h3;
      tick();
      eof = 1'b0; in_valid = 1'b0;
      tick(); tick(); tick();
`ifdef WR_FRAM_PACK_FLUSH_EN
      chk("flush_level", level, 1);
      chk("flush_word", out_data, {160'h0, 32'h3, 32'h2, 32'h1});
      chk("flush_short_req", burst_req, 1);
      burst_ack = 1'b1; tick(); burst_ack = 1'b0;
      chk("flush_ack_drop", burst_req, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      tick(); tick();
      chk("flush_done_level", level, 0);
      chk("flush_done_req", burst_req, 0);
`else
      chk("noflush_level", level, 0);
      chk("noflush_valid", out_valid, 0);
      chk("noflush_req", burst_req, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
